// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, stream framing constants and a header check helper.
package imem_loader_pkg;

  // Stream framing: a 16-bit word count followed by little-endian 32-bit words.
  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int WORD_CNT_W = $clog2(WORD_BYTES);

  // FSM state encoding (3-bit, kept as plain constants for legacy tools).
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_HDR0  = 3'd1;
  localparam state_t ST_HDR1  = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_FLUSH = 3'd4;
  localparam state_t ST_CSUM  = 3'd5;
  localparam state_t ST_RUN   = 3'd6;
  localparam state_t ST_ERROR = 3'd7;

  // A word count is usable when it is non-zero and fits in the memory.
  function automatic logic header_ok(input logic [8*HDR_BYTES-1:0] n,
                                     input int unsigned depth);
    return (n != '0) && ({{(32-8*HDR_BYTES){1'b0}}, n} <= depth);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready port feeding the boot loader.
interface imem_boot_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs accepted stream bytes (LSB first) into 32-bit words. The completed
// word is registered and flagged with a one-cycle word_valid pulse in the
// cycle after its last byte is accepted.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic [WORD_CNT_W-1:0] byte_cnt,
  output logic [31:0]           word,
  output logic                  word_valid
);

  localparam int PACK_W = 8 * (WORD_BYTES - 1);

  logic [WORD_CNT_W-1:0] cnt_q, cnt_d;
  logic [PACK_W-1:0]     pack_q, pack_d;
  logic [31:0]           word_q, word_d;
  logic                  valid_q, valid_d;

  // Shift new bytes in from the top so the first byte ends up in bits [7:0].
  always_comb begin
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      pack_d = '0;
    end else if (byte_en) begin
      cnt_d  = cnt_q + 1'b1;
      pack_d = {byte_in, pack_q[PACK_W-1:8]};
      if (cnt_q == WORD_CNT_W'(WORD_BYTES - 1)) begin
        word_d  = {byte_in, pack_q};
        valid_d = 1'b1;
      end
    end
  end

  // Assembler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pack_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader / access controller for the instruction memory.
// Receives a count-prefixed byte stream, writes the words to consecutive
// addresses, then hands the memory address port to the CPU fetch path and
// releases the CPU from reset.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte over all data bytes before the CPU is released.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset, nothing loaded, CPU held
// HDR0     | waiting for count byte 0 (N[7:0])
// HDR1     | waiting for count byte 1 (N[15:8]), then validate N
// DATA     | receiving 4N data bytes, writing each completed word
// FLUSH    | one cycle carrying the final memory write
// CSUM     | waiting for the checksum byte (checksum build only)
// RUN      | CPU released, memory address follows pc
// ERROR    | load aborted, CPU held until the next start
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 100,
  parameter int ADDR_W    = 7
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  imem_boot_loader_if.slave   rx,
  input  logic [31:0]         pc,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [31:0]         mem_wdata,
  output logic                cpu_run,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                fetch_fault,
  output logic [15:0]         words_loaded
);

  localparam int HDR_BITS = 8 * HDR_BYTES;

  state_t                state_q, state_d;
  logic [7:0]            n_lo_q, n_lo_d;
  logic [HDR_BITS-1:0]   n_q, n_d;
  logic [15:0]           words_q, words_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic                  start_ok;
  logic                  hs;
  logic                  data_hs;
  logic                  word_done;
  logic                  last_word;
  logic [HDR_BITS-1:0]   n_hdr;
  logic [WORD_CNT_W-1:0] byte_cnt;
  logic [31:0]           word;
  logic                  word_valid;
  logic                  in_run;
  logic                  pc_unused;

  // start is honoured only when no load is in flight.
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                              (state_q == ST_ERROR));

  assign rx.rx_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                       (state_q == ST_DATA) || (state_q == ST_CSUM);

  assign hs        = rx.rx_valid && rx.rx_ready;
  assign data_hs   = hs && (state_q == ST_DATA);
  assign word_done = data_hs && (byte_cnt == WORD_CNT_W'(WORD_BYTES - 1));
  assign last_word = word_done && (words_q == (n_q - 16'd1));
  assign n_hdr     = {rx.rx_data, n_lo_q};

  word_assembler u_word_assembler (
    .clk        (CLK),
    .rst_n      (RST_N),
    .clr        (start_ok),
    .byte_en    (data_hs),
    .byte_in    (rx.rx_data),
    .byte_cnt   (byte_cnt),
    .word       (word),
    .word_valid (word_valid)
  );

  // Next-state, header capture, word counting and completion flag.
  always_comb begin
    state_d   = state_q;
    n_lo_d    = n_lo_q;
    n_d       = n_q;
    words_d   = words_q;
    wr_addr_d = wr_addr_q;
    done_d    = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (start_ok) begin
      state_d = ST_HDR0;
      words_d = '0;
      done_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_HDR0: begin
          if (hs) begin
            n_lo_d  = rx.rx_data;
            state_d = ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (hs) begin
            n_d     = n_hdr;
            state_d = header_ok(n_hdr, MEM_DEPTH) ? ST_DATA : ST_ERROR;
          end
        end
        ST_DATA: begin
          if (data_hs) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ rx.rx_data;
`endif
            if (word_done) begin
              wr_addr_d = words_q[ADDR_W-1:0];
              words_d   = words_q + 16'd1;
            end
            if (last_word) begin
              state_d = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_RUN;
          done_d  = 1'b1;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (hs) begin
            if (rx.rx_data == csum_q) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Controller registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      n_lo_q    <= '0;
      n_q       <= '0;
      words_q   <= '0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_lo_q    <= n_lo_d;
      n_q       <= n_d;
      words_q   <= words_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Single owner of the address port: loader write, else CPU fetch, else 0.
  always_comb begin
    if (word_valid) begin
      mem_addr = wr_addr_q;
    end else if (in_run) begin
      mem_addr = pc[ADDR_W+1:2];
    end else begin
      mem_addr = '0;
    end
  end

  assign in_run       = (state_q == ST_RUN);
  assign mem_we       = word_valid;
  assign mem_wdata    = word;
  assign cpu_run      = in_run;
  assign busy         = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                        (state_q == ST_DATA) || (state_q == ST_FLUSH) ||
                        (state_q == ST_CSUM);
  assign done         = done_q;
  assign error        = (state_q == ST_ERROR);
  assign fetch_fault  = in_run && (pc[31:2] >= 30'(MEM_DEPTH));
  assign words_loaded = words_q;

  // Byte-offset bits of pc never select a word.
  assign pc_unused = ^pc[1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random word loads (with and
// without valid gaps) against an expected-write queue, header rejection,
// fetch address mapping, mid-load reset and, when built with
// IMEM_LOADER_CHECKSUM_EN, checksum accept/reject.
module tb_imem_boot_loader;

  localparam int MEM_DEPTH = 100;
  localparam int ADDR_W    = 7;

  logic                CLK;
  logic                RST_N;
  logic                start;
  logic [31:0]         pc;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [31:0]         mem_wdata;
  logic                cpu_run;
  logic                busy;
  logic                done;
  logic                error;
  logic                fetch_fault;
  logic [15:0]         words_loaded;

  imem_boot_loader_if rx_if ();

  imem_boot_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .rx           (rx_if),
    .pc           (pc),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .fetch_fault  (fetch_fault),
    .words_loaded (words_loaded)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] ld_words[$];
  logic [38:0] exp_q[$];
  logic [38:0] wr_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every memory write must match the next expected (address, data) pair.
  always @(negedge CLK) begin
    if (RST_N && mem_we) begin
      chk("we_owner", {cpu_run, error}, 0);
      if (exp_q.size() == 0) begin
        chk("spurious_we", 1, 0);
      end else begin
        wr_e = exp_q.pop_front();
        chk("we_addr", mem_addr, wr_e[38:32]);
        chk("we_data", mem_wdata, wr_e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, rx_if.rx_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_words"}, words_loaded, 0);
    chk({tag, "_fault"}, fetch_fault, 0);
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    bit ok;
    ok = 1'b0;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin
      @(posedge CLK);
      #1;
    end
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge CLK);
      ok = rx_if.rx_ready;
    end
    chk("hs_taken", ok, 1);
    @(posedge CLK);
    #1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic after_start_checks();
    chk("start_cpu_run", cpu_run, 0);
    chk("start_busy", busy, 1);
    chk("start_words", words_loaded, 0);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("hdr_mem_addr", mem_addr, 0);
    chk("hdr_rx_ready", rx_if.rx_ready, 1);
  endtask

  task automatic run_load(input bit gaps, input bit bad_csum);
    int n;
    logic [7:0] x;
    logic [7:0] b;
    n = ld_words.size();
    x = 8'h00;
    pulse_start();
    after_start_checks();
    for (int i = 0; i < n; i++) exp_q.push_back({7'(i), ld_words[i]});
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(ld_words[i] >> (8 * k));
        x = x ^ b;
        send_byte(b, gaps);
      end
    end
    chk("flush_we", mem_we, 1);
    chk("flush_cpu_run", cpu_run, 0);
    chk("flush_busy", busy, 1);
    chk("flush_fault", fetch_fault, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
    chk("csum_cpu_run", cpu_run, !bad_csum);
    chk("csum_done", done, !bad_csum);
    chk("csum_error", error, bad_csum);
`else
    chk("no_csum_flag", bad_csum, 0);
    @(posedge CLK);
    #1;
    chk("run_cpu_run", cpu_run, 1);
    chk("run_done", done, 1);
    chk("run_error", error, 0);
`endif
    chk("end_words", words_loaded, n);
    chk("end_busy", busy, 0);
    chk("end_rx_ready", rx_if.rx_ready, 0);
    chk("writes_pending", exp_q.size(), 0);
  endtask

  task automatic hdr_err(input int n);
    pulse_start();
    after_start_checks();
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    chk("hdr_err_error", error, 1);
    chk("hdr_err_cpu_run", cpu_run, 0);
    chk("hdr_err_busy", busy, 0);
    chk("hdr_err_done", done, 0);
    rx_if.rx_valid = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      #1;
      chk("hdr_err_rx_ready", rx_if.rx_ready, 0);
      chk("hdr_err_hold", error, 1);
    end
    rx_if.rx_valid = 1'b0;
  endtask

  // Expected fetch mapping: word index modulo the address range, fault past depth.
  task automatic pc_check(input logic [31:0] p);
    pc = p;
    #1;
    chk("pc_mem_addr", mem_addr, (p >> 2) % (1 << ADDR_W));
    chk("pc_fault", fetch_fault, (p >> 2) >= MEM_DEPTH);
    pc = 32'h190;
  endtask

  task automatic random_words(input int n);
    ld_words.delete();
    for (int i = 0; i < n; i++) ld_words.push_back($urandom);
  endtask

  initial begin
    RST_N          = 1'b1;
    start          = 1'b0;
    pc             = 32'h190;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    #1 RST_N = 1'b0;
    #3;
    check_reset_outputs("rst");
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_reset_outputs("idle");

    // Reference program, byte-per-cycle, then fetch mapping in RUN.
    ld_words = '{32'h20080005, 32'h20090007, 32'h01095020};
    run_load(1'b0, 1'b0);
    pc_check(32'h8);
    pc_check(32'h0);
    pc_check(32'h18C);
    pc_check(32'h190);
    pc_check(32'h200);
    for (int i = 0; i < 6; i++) pc_check($urandom);

    // Same program with valid gaps, restarted from RUN.
    run_load(1'b1, 1'b0);

    // Rejected headers.
    hdr_err(0);
    hdr_err(101);
    hdr_err(int'($urandom_range(102, 65535)));

    // Boundary and random loads.
    random_words(1);
    run_load(1'b0, 1'b0);
    random_words(MEM_DEPTH);
    run_load(1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      random_words(int'($urandom_range(2, 10)));
      run_load(1'($urandom), 1'b0);
    end

    // Reset in the middle of a load.
    random_words(3);
    pulse_start();
    after_start_checks();
    for (int i = 0; i < 3; i++) exp_q.push_back({7'(i), ld_words[i]});
    send_byte(8'd3, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(8'(ld_words[k / 4] >> (8 * (k % 4))), 1'b0);
    chk("midload_pending", exp_q.size(), 2);
    #2 RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    #10 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_reset_outputs("postrst");
    random_words(1);
    run_load(1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    ld_words = '{32'h20080005};
    run_load(1'b0, 1'b0);
    run_load(1'b0, 1'b1);
    random_words(4);
    run_load(1'b1, 1'b1);
    random_words(5);
    run_load(1'b1, 1'b0);
`endif

    repeat (3) @(posedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
